pipe_trace_monitor: RTL and testbench

PIPE_TRACE_MONITOR -- requirements
Module: pipe_trace_monitor

---
 rtl/pipe_trace_monitor.sv | 234 +++++++++++++++++++++++
 tb/tb_pipe_trace_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_monitor.sv
// Pipeline lifecycle tracer: stamps per-tag stage events, emits
// a trace record per retire, reports protocol errors and hangs.
module pipe_trace_monitor #(
  parameter int NUM_ENTRIES = 32,
  parameter int NUM_STAGES  = 6,
  parameter int TS_W        = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_W   = 16,
  parameter int TAG_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_STAGES-1:0]      stage_valid,
  input  logic [NUM_STAGES*TAG_W-1:0] stage_tag,
  input  logic                       retire_valid,
  input  logic [TAG_W-1:0]           retire_tag,
  input  logic                       flush,
  input  logic [TIMEOUT_W-1:0]       timeout_cfg,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [TAG_W-1:0]           trc_tag,
  output logic [NUM_STAGES*TS_W-1:0] trc_ts,
  output logic [NUM_STAGES-1:0]      trc_done,
  output logic [TS_W-1:0]            trc_retire_ts,
  output logic                       err_valid,
  output logic [2:0]                 err_code,
  output logic [TAG_W-1:0]           err_tag,
  output logic                       err_multi,
  output logic                       hang
);

  localparam int REC_W = TAG_W + NUM_STAGES*TS_W + NUM_STAGES + TS_W;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_DUP_ALLOC = 3'd1;
  localparam logic [2:0] ERR_NO_ENTRY  = 3'd2;
  localparam logic [2:0] ERR_DUP_STAGE = 3'd3;
  localparam logic [2:0] ERR_NO_RESULT = 3'd4;
  localparam logic [2:0] ERR_TRC_OVF   = 3'd5;

  logic [TS_W-1:0]       ts;
  logic                  valid_q [NUM_ENTRIES];
  logic [NUM_STAGES-1:0] done_q  [NUM_ENTRIES];
  logic [TS_W-1:0]       stamp_q [NUM_ENTRIES][NUM_STAGES];
  logic [TAG_W-1:0]      stg_tag [NUM_STAGES];

  logic [NUM_STAGES-1:0]      stg_upd;
  logic                       ret_hit;
  logic [NUM_STAGES-1:0]      rec_done;
  logic [NUM_STAGES*TS_W-1:0] rec_ts;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic [2:0]                 err_code_d;
  logic [TAG_W-1:0]           err_tag_d;
  logic [7:0]                 n_err;
  logic                       any_valid;

  logic [REC_W-1:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [TIMEOUT_W-1:0] wd;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++)
      stg_tag[k] = stage_tag[k*TAG_W +: TAG_W];
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      any_valid = any_valid | valid_q[i];
  end

  assign pop  = trc_valid && trc_ready;
  assign full = (count == CW'(FIFO_DEPTH));

  // Errors are visited lowest priority first so later hits override.
  always_comb begin
    stg_upd    = '0;
    ret_hit    = 1'b0;
    rec_done   = '0;
    rec_ts     = '0;
    push       = 1'b0;
    err_code_d = ERR_NONE;
    err_tag_d  = '0;
    n_err      = '0;
    if (!flush) begin
      if (stage_valid[0]) begin
        if (!valid_q[stg_tag[0]] ||
            (retire_valid && retire_tag == stg_tag[0])) begin
          stg_upd[0] = 1'b1;
        end else begin
          err_code_d = ERR_DUP_ALLOC;
          err_tag_d  = stg_tag[0];
          n_err      = n_err + 8'd1;
        end
      end
      for (int k = NUM_STAGES-1; k >= 1; k--) begin
        if (stage_valid[k]) begin
          if (!valid_q[stg_tag[k]]) begin
            err_code_d = ERR_NO_ENTRY;
            err_tag_d  = stg_tag[k];
            n_err      = n_err + 8'd1;
          end else if (done_q[stg_tag[k]][k]) begin
            err_code_d = ERR_DUP_STAGE;
            err_tag_d  = stg_tag[k];
            n_err      = n_err + 8'd1;
          end else begin
            stg_upd[k] = 1'b1;
          end
        end
      end
      if (retire_valid) begin
        if (!valid_q[retire_tag]) begin
          err_code_d = ERR_NO_ENTRY;
          err_tag_d  = retire_tag;
          n_err      = n_err + 8'd1;
        end else begin
          ret_hit  = 1'b1;
          rec_done = done_q[retire_tag];
          for (int k = 0; k < NUM_STAGES; k++)
            rec_ts[k*TS_W +: TS_W] = stamp_q[retire_tag][k];
          for (int k = 1; k < NUM_STAGES; k++) begin
            if (stg_upd[k] && stg_tag[k] == retire_tag) begin
              rec_done[k]            = 1'b1;
              rec_ts[k*TS_W +: TS_W] = ts;
            end
          end
          if (!rec_done[NUM_STAGES-1]) begin
            err_code_d = ERR_NO_RESULT;
            err_tag_d  = retire_tag;
            n_err      = n_err + 8'd1;
          end
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            err_code_d = ERR_TRC_OVF;
            err_tag_d  = retire_tag;
            n_err      = n_err + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  // Alloc is applied last so it re-opens an entry retired this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        done_q[i]  <= '0;
        for (int k = 0; k < NUM_STAGES; k++)
          stamp_q[i][k] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        valid_q[i] <= 1'b0;
    end else begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (stg_upd[k]) begin
          done_q[stg_tag[k]][k]  <= 1'b1;
          stamp_q[stg_tag[k]][k] <= ts;
        end
      end
      if (ret_hit) valid_q[retire_tag] <= 1'b0;
      if (stg_upd[0]) begin
        valid_q[stg_tag[0]]    <= 1'b1;
        done_q[stg_tag[0]]     <= NUM_STAGES'(1);
        stamp_q[stg_tag[0]][0] <= ts;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= {retire_tag, rec_ts, rec_done, ts};
        wr_ptr         <= inc_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= inc_ptr(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign trc_valid = (count != '0);
  assign {trc_tag, trc_ts, trc_done, trc_retire_ts} = fifo_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_tag   <= '0;
      err_multi <= 1'b0;
    end else begin
      err_valid <= (n_err != '0);
      if (n_err != '0) begin
        err_code  <= err_code_d;
        err_tag   <= err_tag_d;
        err_multi <= (n_err > 8'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd   <= '0;
      hang <= 1'b0;
    end else begin
      if (flush || retire_valid) wd <= '0;
      else if (wd != '1)         wd <= wd + TIMEOUT_W'(1);
      if (timeout_cfg != '0 && wd == timeout_cfg && any_valid)
        hang <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench for pipe_trace_monitor: lifecycle records, error
// codes and priority, FIFO overflow/drain, flush and hang watchdog.
module tb_pipe_trace_monitor;

  localparam int NS = 6;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] stage_valid;
  logic [NS*TW-1:0] stage_tag;
  logic          retire_valid;
  logic [TW-1:0] retire_tag;
  logic          flush;
  logic [15:0]   timeout_cfg;
  logic          trc_valid;
  logic          trc_ready;
  logic [TW-1:0] trc_tag;
  logic [NS*16-1:0] trc_ts;
  logic [NS-1:0] trc_done;
  logic [15:0]   trc_retire_ts;
  logic          err_valid;
  logic [2:0]    err_code;
  logic [TW-1:0] err_tag;
  logic          err_multi;
  logic          hang;

  int checks = 0;
  int errors = 0;

  pipe_trace_monitor dut (
    .clk(clk), .reset(reset),
    .stage_valid(stage_valid), .stage_tag(stage_tag),
    .retire_valid(retire_valid), .retire_tag(retire_tag),
    .flush(flush), .timeout_cfg(timeout_cfg),
    .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_tag(trc_tag), .trc_ts(trc_ts), .trc_done(trc_done),
    .trc_retire_ts(trc_retire_ts),
    .err_valid(err_valid), .err_code(err_code),
    .err_tag(err_tag), .err_multi(err_multi), .hang(hang)
  );

  always #5 clk = ~clk;

  task automatic clr();
    stage_valid  = '0;
    stage_tag    = '0;
    retire_valid = 1'b0;
    retire_tag   = '0;
    flush        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic stg(input int k, input int t);
    stage_valid[k] = 1'b1;
    stage_tag[k*TW +: TW] = TW'(t);
  endtask

  task automatic ret(input int t);
    retire_valid = 1'b1;
    retire_tag   = TW'(t);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trc_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    trc_ready = 1'b0;
    timeout_cfg = 16'd1;
    stage_valid = '1;
    ret(3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr();
    timeout_cfg = 16'd0;
    reset = 1'b0;
    checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL rst_trc_valid got %0b exp 0", trc_valid); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL rst_err_valid got %0b exp 0", err_valid); end
    checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL rst_err_code got %0d exp 0", err_code); end
    checks++; if (err_tag !== 5'd0) begin errors++; $display("FAIL rst_err_tag got %0d exp 0", err_tag); end
    checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL rst_err_multi got %0b exp 0", err_multi); end
    checks++; if (hang !== 1'b0) begin errors++; $display("FAIL rst_hang got %0b exp 0", hang); end
  endtask

  task automatic test_lifecycle();
    logic [NS*16-1:0] exp_ts;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    stg(0, 3); step();
    for (int k = 1; k < NS; k++) begin stg(k, 3); step(); end
    ret(3); step();
    for (int k = 0; k < NS; k++) exp_ts[k*16 +: 16] = 16'(10 + k);
    checks++; if (trc_valid !== 1'b1) begin errors++; $display("FAIL life_valid got %0b exp 1", trc_valid); end
    checks++; if (trc_tag !== 5'd3) begin errors++; $display("FAIL life_tag got %0d exp 3", trc_tag); end
    checks++; if (trc_ts !== exp_ts) begin errors++; $display("FAIL life_ts got %h exp %h", trc_ts, exp_ts); end
    checks++; if (trc_done !== 6'h3F) begin errors++; $display("FAIL life_done got %h exp 3f", trc_done); end
    checks++; if (trc_retire_ts !== 16'd16) begin errors++; $display("FAIL life_rts got %0d exp 16", trc_retire_ts); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL life_err got %0b exp 0", err_valid); end
    trc_ready = 1'b1; step(); trc_ready = 1'b0;
    checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL life_pop got %0b exp 0", trc_valid); end
  endtask

  task automatic test_no_result();
    do_reset();
    stg(0, 5); step();
    for (int k = 1; k < 4; k++) begin stg(k, 5); step(); end
    stg(4, 5); ret(5); step();
    checks++; if (trc_done !== 6'h1F) begin errors++; $display("FAIL nores_done got %h exp 1f", trc_done); end
    checks++; if (trc_ts[4*16 +: 16] !== 16'd4) begin errors++; $display("FAIL nores_s4 got %0d exp 4", trc_ts[4*16 +: 16]); end
    checks++; if (trc_retire_ts !== 16'd4) begin errors++; $display("FAIL nores_rts got %0d exp 4", trc_retire_ts); end
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL nores_ev got %0b exp 1", err_valid); end
    checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL nores_code got %0d exp 4", err_code); end
    checks++; if (err_tag !== 5'd5) begin errors++; $display("FAIL nores_tag got %0d exp 5", err_tag); end
    checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL nores_multi got %0b exp 0", err_multi); end
    step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL nores_pulse got %0b exp 0", err_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      stg(0, 8 + i); step();
      stg(5, 8 + i); step();
    end
    for (int i = 0; i < 4; i++) begin
      ret(8 + i); step();
      checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL ovf_fill%0d got %0b exp 0", i, err_valid); end
    end
    ret(12); step();
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL ovf_ev got %0b exp 1", err_valid); end
    checks++; if (err_code !== 3'd5) begin errors++; $display("FAIL ovf_code got %0d exp 5", err_code); end
    checks++; if (err_tag !== 5'd12) begin errors++; $display("FAIL ovf_tag got %0d exp 12", err_tag); end
    ret(12); step();
    checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL ovf_freed got %0d exp 2", err_code); end
    trc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (trc_valid !== 1'b1) begin errors++; $display("FAIL drain%0d_valid got %0b exp 1", i, trc_valid); end
      checks++; if (trc_tag !== TW'(8 + i)) begin errors++; $display("FAIL drain%0d_tag got %0d exp %0d", i, trc_tag, 8 + i); end
      checks++; if (trc_retire_ts !== 16'(10 + i)) begin errors++; $display("FAIL drain%0d_rts got %0d exp %0d", i, trc_retire_ts, 10 + i); end
      checks++; if (trc_ts[0 +: 16] !== 16'(2 * i)) begin errors++; $display("FAIL drain%0d_s0 got %0d exp %0d", i, trc_ts[0 +: 16], 2 * i); end
      checks++; if (trc_ts[5*16 +: 16] !== 16'(2 * i + 1)) begin errors++; $display("FAIL drain%0d_s5 got %0d exp %0d", i, trc_ts[5*16 +: 16], 2 * i + 1); end
      checks++; if (trc_done !== 6'h21) begin errors++; $display("FAIL drain%0d_done got %h exp 21", i, trc_done); end
      step();
    end
    trc_ready = 1'b0;
    checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", trc_valid); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    stg(0, 7); step();
    stg(2, 7); step();
    stg(2, 7); ret(7); step();
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL prio_ev got %0b exp 1", err_valid); end
    checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL prio_code got %0d exp 4", err_code); end
    checks++; if (err_tag !== 5'd7) begin errors++; $display("FAIL prio_tag got %0d exp 7", err_tag); end
    checks++; if (err_multi !== 1'b1) begin errors++; $display("FAIL prio_multi got %0b exp 1", err_multi); end
    checks++; if (trc_done !== 6'h05) begin errors++; $display("FAIL prio_done got %h exp 05", trc_done); end
    trc_ready = 1'b1; step(); trc_ready = 1'b0;
    stg(0, 7); step();
    stg(5, 7); step();
    stg(0, 7); ret(7); step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reopen_err got %0b exp 0", err_valid); end
    stg(5, 7); step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reopen_stg got %0b exp 0", err_valid); end
    ret(7); step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reopen_ret got %0b exp 0", err_valid); end
    checks++; if (trc_ts[0 +: 16] !== 16'd4) begin errors++; $display("FAIL recA_s0 got %0d exp 4", trc_ts[0 +: 16]); end
    checks++; if (trc_retire_ts !== 16'd6) begin errors++; $display("FAIL recA_rts got %0d exp 6", trc_retire_ts); end
    trc_ready = 1'b1; step(); trc_ready = 1'b0;
    checks++; if (trc_ts[0 +: 16] !== 16'd6) begin errors++; $display("FAIL recB_s0 got %0d exp 6", trc_ts[0 +: 16]); end
    checks++; if (trc_ts[5*16 +: 16] !== 16'd7) begin errors++; $display("FAIL recB_s5 got %0d exp 7", trc_ts[5*16 +: 16]); end
    checks++; if (trc_done !== 6'h21) begin errors++; $display("FAIL recB_done got %h exp 21", trc_done); end
  endtask

  task automatic test_flush();
    do_reset();
    stg(0, 2); step();
    flush = 1'b1; stg(1, 2); ret(2); step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL flush_err got %0b exp 0", err_valid); end
    checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL flush_rec got %0b exp 0", trc_valid); end
    stg(1, 2); step();
    checks++; if (err_code !== 3'd2 || err_valid !== 1'b1) begin errors++; $display("FAIL flush_gone got %0d/%0b exp 2/1", err_code, err_valid); end
    stg(0, 2); stg(3, 2); step();
    checks++; if (err_code !== 3'd2 || err_tag !== 5'd2) begin errors++; $display("FAIL alloc_stg got %0d/%0d exp 2/2", err_code, err_tag); end
    checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL alloc_stg_multi got %0b exp 0", err_multi); end
    stg(3, 2); step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL alloc_open got %0b exp 0", err_valid); end
  endtask

  task automatic test_hang();
    timeout_cfg = 16'd40;
    do_reset();
    stg(0, 1); step();
    for (int i = 2; i <= 40; i++) step();
    checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_early got %0b exp 0", hang); end
    step();
    checks++; if (hang !== 1'b1) begin errors++; $display("FAIL hang_set got %0b exp 1", hang); end
    ret(1); step(); step();
    checks++; if (hang !== 1'b1) begin errors++; $display("FAIL hang_sticky got %0b exp 1", hang); end
    do_reset();
    checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_rst got %0b exp 0", hang); end
    stg(0, 1); step();
    for (int i = 2; i < 30; i++) step();
    flush = 1'b1; step();
    for (int i = 31; i <= 80; i++) step();
    checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_flush got %0b exp 0", hang); end
    timeout_cfg = 16'd0;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    trc_ready = 1'b0;
    timeout_cfg = 16'd0;
    test_reset();
    test_lifecycle();
    test_no_result();
    test_overflow();
    test_same_cycle();
    test_flush();
    test_hang();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
